mmio_input_port: RTL and testbench

//  Memory-mapped input peripheral: the read-side counterpart of the processor's MMIO write path to the VGA dot registers.

---
 rtl/mmio_input_port_if.sv | 27 ++
 rtl/mmio_input_port.sv | 115 +++++++++++
 tb/tb_mmio_input_port.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_input_port_if.sv
// ============================================================================
// Module      : mmio_input_port_if
// Description : Processor dmem bus as seen by the MMIO input port (address,
//               store path and read-mux return).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mmio_input_port_if;
  logic [31:0] mem_addr;
  logic        mem_wren;
  logic [31:0] mem_wdata;
  logic        rd_hit;
  logic [31:0] rd_data;

  modport master (
    output mem_addr, mem_wren, mem_wdata,
    input  rd_hit, rd_data
  );

  modport slave (
    input  mem_addr, mem_wren, mem_wdata,
    output rd_hit, rd_data
  );
endinterface

`default_nettype wire

// File: rtl/mmio_input_port.sv
// ============================================================================
// Module      : mmio_input_port
// Description : Synchronized, debounced buttons/switches with latched press
//               events, read through two dmem addresses, write-1-to-clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_input_port #(
  parameter int NUM_BTN         = 1,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int ADDR_BTN        = 97,
  parameter int ADDR_SW         = 98
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [4:0]         sw_raw,
  mmio_input_port_if.slave   bus
);

  localparam int            NB       = NUM_BTN + 5;
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NB-1:0]      raw;
  logic [NB-1:0]      sync1;
  logic [NB-1:0]      sync2;
  logic [NB-1:0]      level;
  logic [CW-1:0]      cnt [NB];
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_level_d;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] clr_mask;
  logic [7:0]         press_count;
  logic [3:0]         npress;
  logic [8:0]         count_sum;
  logic               btn_sel;
  logic               sw_sel;
  logic               clr_hit;
  logic               clr_cnt;
  logic               unused_wdata;

  // Buttons occupy the low bits, switches the top five.
  assign raw = {sw_raw, btn_raw};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          level[i] <= sync2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign btn_level = level[NUM_BTN-1:0];
  assign press     = btn_level & ~btn_level_d;

  always_comb begin
    npress = '0;
    for (int i = 0; i < NUM_BTN; i++) npress = npress + 4'(press[i]);
  end

  assign btn_sel   = (bus.mem_addr == 32'(ADDR_BTN));
  assign sw_sel    = (bus.mem_addr == 32'(ADDR_SW));
  assign clr_hit   = bus.mem_wren && btn_sel;
  assign clr_mask  = clr_hit ? bus.mem_wdata[8 +: NUM_BTN] : '0;
  assign clr_cnt   = clr_hit && bus.mem_wdata[31];
  assign count_sum = {1'b0, press_count} + {5'd0, npress};

  // A press landing in the same cycle as its clear keeps the bit set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_level_d <= '0;
      pending     <= '0;
      press_count <= '0;
    end else begin
      btn_level_d <= btn_level;
      pending     <= (pending & ~clr_mask) | press;
      if (clr_cnt)
        press_count <= 8'(npress);
      else
        press_count <= count_sum[8] ? 8'hFF : count_sum[7:0];
    end
  end

  assign bus.rd_hit = btn_sel || sw_sel;

  always_comb begin
    bus.rd_data = '0;
    if (btn_sel)
      bus.rd_data = {8'h00, press_count, 8'(pending), 8'(btn_level)};
    else if (sw_sel)
      bus.rd_data = {27'd0, level[NUM_BTN +: 5]};
  end

  assign unused_wdata = ^bus.mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mmio_input_port.sv
// ============================================================================
// Module      : tb_mmio_input_port
// Description : Directed and randomized bench for mmio_input_port against a
//               pin-history reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_input_port;

  localparam int D    = 8;
  localparam int NBTN = 2;

  logic            clock;
  logic            reset;
  logic [NBTN-1:0] btn_raw;
  logic [4:0]      sw_raw;
  int              n_checks = 0;
  int              n_pass   = 0;

  mmio_input_port_if bus ();

  mmio_input_port #(
    .NUM_BTN(NBTN), .DEBOUNCE_CYCLES(D), .ADDR_BTN(97), .ADDR_SW(98)
  ) dut (
    .clock(clock), .reset(reset), .btn_raw(btn_raw), .sw_raw(sw_raw), .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: a level flips once the pin value seen two clocks ago has
  // disagreed with it for D consecutive samples; presses apply one clock later.
  logic [6:0] ph [0:D+1];
  logic [6:0] mlev, mrose, nl;
  logic [1:0] mpend, pr;
  int         mcount, np;
  bit         all_diff;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= D + 1; k++) ph[k] = '0;
      mlev = '0; mrose = '0; mpend = '0; mcount = 0;
    end else begin
      pr = mrose[1:0];
      np = int'(pr[0]) + int'(pr[1]);
      if (bus.mem_wren && bus.mem_addr == 32'd97) begin
        mpend = mpend & ~bus.mem_wdata[9:8];
        if (bus.mem_wdata[31]) mcount = 0;
      end
      mpend  = mpend | pr;
      mcount = (mcount + np > 255) ? 255 : mcount + np;
      for (int k = D + 1; k > 0; k--) ph[k] = ph[k-1];
      ph[0] = {sw_raw, btn_raw};
      nl = mlev;
      for (int b = 0; b < 7; b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < D; j++) if (ph[2+j][b] == mlev[b]) all_diff = 1'b0;
        if (all_diff) nl[b] = ~mlev[b];
      end
      mrose = nl & ~mlev;
      mlev  = nl;
    end
  end

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    if (a == 32'd97) return {8'h00, mcount[7:0], 6'd0, mpend, 6'd0, mlev[1:0]};
    if (a == 32'd98) return {27'd0, mlev[6:2]};
    return 32'h0;
  endfunction

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    bus.mem_addr = a; bus.mem_wren = 1'b1; bus.mem_wdata = d;
    @(negedge clock);
    bus.mem_wren = 1'b0; bus.mem_addr = 32'd97;
    #1;
  endtask

  // Press btn0 with a store to 97 landing on the edge that registers the press.
  task automatic press_with_store(input logic [31:0] d);
    @(negedge clock);
    btn_raw[0] = 1'b1;
    repeat (D + 2) @(negedge clock);
    bus.mem_addr = 32'd97; bus.mem_wren = 1'b1; bus.mem_wdata = d;
    @(negedge clock);
    bus.mem_wren = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] addrs [3];
    addrs = '{32'd97, 32'd98, 32'd500};
    reset = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      bus.mem_addr = addrs[i];
      #1;
      n_checks++;
      if (bus.rd_hit !== (i < 2)) $display("FAIL reset_hit addr=%0d got=%b want=%b", addrs[i], bus.rd_hit, (i < 2));
      else n_pass++;
      n_checks++;
      if (bus.rd_data !== 32'h0) $display("FAIL reset_data addr=%0d got=%h want=0", addrs[i], bus.rd_data);
      else n_pass++;
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_clean_press();
    bus.mem_addr = 32'd97;
    @(negedge clock);
    btn_raw[0] = 1'b1;
    repeat (D + 1) @(negedge clock);
    #1;
    n_checks++;
    if (bus.rd_data !== 32'h0) $display("FAIL press_early got=%h want=00000000", bus.rd_data);
    else n_pass++;
    @(negedge clock); #1;
    n_checks++;
    if (bus.rd_data !== 32'h1) $display("FAIL press_level got=%h want=00000001", bus.rd_data);
    else n_pass++;
    @(negedge clock); #1;
    n_checks++;
    if (bus.rd_data !== 32'h0001_0101) $display("FAIL press_event got=%h want=00010101", bus.rd_data);
    else n_pass++;
    btn_raw[0] = 1'b0;
    repeat (20) @(negedge clock);
    #1;
    n_checks++;
    if (bus.rd_data !== 32'h0001_0100) $display("FAIL release got=%h want=00010100", bus.rd_data);
    else n_pass++;
  endtask

  task automatic test_bounce();
    do_store(32'd97, 32'h8000_0300);
    n_checks++;
    if (bus.rd_data !== 32'h0) $display("FAIL bounce_clear got=%h want=00000000", bus.rd_data);
    else n_pass++;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      btn_raw[0] = ((c / 3) % 2 == 0);
      #1;
      n_checks++;
      if (bus.rd_data !== exp_read(32'd97)) $display("FAIL bounce_cycle c=%0d got=%h want=%h", c, bus.rd_data, exp_read(32'd97));
      else n_pass++;
    end
    @(negedge clock);
    btn_raw[0] = 1'b1;
    repeat (20) @(negedge clock);
    #1;
    n_checks++;
    if (bus.rd_data !== 32'h0001_0101) $display("FAIL bounce_once got=%h want=00010101", bus.rd_data);
    else n_pass++;
  endtask

  task automatic test_w1c();
    logic [31:0] stores [4];
    logic [31:0] wants  [4];
    stores = '{32'hFFFF_FFFF, 32'h7FFF_00FF, 32'h0000_0100, 32'h8000_0000};
    wants  = '{32'h0001_0101, 32'h0001_0101, 32'h0001_0001, 32'h0000_0001};
    for (int i = 0; i < 4; i++) begin
      do_store((i == 0) ? 32'd98 : 32'd97, stores[i]);
      n_checks++;
      if (bus.rd_data !== wants[i]) $display("FAIL w1c_store%0d got=%h want=%h", i, bus.rd_data, wants[i]);
      else n_pass++;
    end
    btn_raw[0] = 1'b0;
    repeat (20) @(negedge clock);
    press_with_store(32'h0000_0100);
    n_checks++;
    if (bus.rd_data !== 32'h0001_0101) $display("FAIL w1c_set_wins got=%h want=00010101", bus.rd_data);
    else n_pass++;
    btn_raw[0] = 1'b0;
    repeat (20) @(negedge clock);
    press_with_store(32'h8000_0100);
    n_checks++;
    if (bus.rd_data !== 32'h0001_0101) $display("FAIL w1c_count_clear_press got=%h want=00010101", bus.rd_data);
    else n_pass++;
  endtask

  task automatic test_saturation();
    btn_raw[0] = 1'b0;
    repeat (20) @(negedge clock);
    for (int p = 0; p < 300; p++) begin
      btn_raw[0] = 1'b1;
      repeat (D + 4) @(negedge clock);
      btn_raw[0] = 1'b0;
      repeat (D + 4) @(negedge clock);
    end
    #1;
    n_checks++;
    if (bus.rd_data !== 32'h00FF_0100) $display("FAIL saturate got=%h want=00ff0100", bus.rd_data);
    else n_pass++;
    press_with_store(32'h8000_0000);
    n_checks++;
    if (bus.rd_data !== 32'h0001_0101) $display("FAIL sat_clear_press got=%h want=00010101", bus.rd_data);
    else n_pass++;
  endtask

  task automatic test_multi();
    btn_raw = 2'b00;
    repeat (20) @(negedge clock);
    do_store(32'd97, 32'h8000_0300);
    @(negedge clock);
    btn_raw = 2'b11;
    repeat (25) @(negedge clock);
    #1;
    n_checks++;
    if (bus.rd_data !== 32'h0002_0303) $display("FAIL multi_press got=%h want=00020303", bus.rd_data);
    else n_pass++;
    do_store(32'd97, 32'h0000_0200);
    n_checks++;
    if (bus.rd_data !== 32'h0002_0103) $display("FAIL multi_clear1 got=%h want=00020103", bus.rd_data);
    else n_pass++;
  endtask

  task automatic test_switches();
    btn_raw = 2'b00;
    repeat (20) @(negedge clock);
    bus.mem_addr = 32'd98;
    sw_raw = 5'b10110;
    repeat (D + 1) @(negedge clock);
    #1;
    n_checks++;
    if (bus.rd_data !== 32'h0) $display("FAIL sw_early got=%h want=00000000", bus.rd_data);
    else n_pass++;
    @(negedge clock); #1;
    n_checks++;
    if (bus.rd_data !== 32'h16) $display("FAIL sw_level got=%h want=00000016", bus.rd_data);
    else n_pass++;
    sw_raw[0] = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clock);
      if (c == 4) sw_raw[0] = 1'b0;
      #1;
      n_checks++;
      if (bus.rd_data !== 32'h16) $display("FAIL sw_glitch c=%0d got=%h want=00000016", c, bus.rd_data);
      else n_pass++;
    end
    btn_raw[0] = 1'b1;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.rd_data !== 32'h0) $display("FAIL sw_reset got=%h want=00000000", bus.rd_data);
    else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    repeat (D + 1) @(negedge clock);
    #1;
    n_checks++;
    if (bus.rd_data !== 32'h0) $display("FAIL sw_requal_early got=%h want=00000000", bus.rd_data);
    else n_pass++;
    @(negedge clock); #1;
    n_checks++;
    if (bus.rd_data !== 32'h16) $display("FAIL sw_requal got=%h want=00000016", bus.rd_data);
    else n_pass++;
    @(negedge clock);
    bus.mem_addr = 32'd97;
    #1;
    n_checks++;
    if (bus.rd_data !== 32'h0001_0101) $display("FAIL reset_held_press got=%h want=00010101", bus.rd_data);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] addrs [4];
    addrs = '{32'd97, 32'd98, 32'd99, 32'd500};
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      for (int b = 0; b < NBTN; b++) if ($urandom_range(0, 9) == 0) btn_raw[b] = ~btn_raw[b];
      for (int b = 0; b < 5; b++) if ($urandom_range(0, 9) == 0) sw_raw[b] = ~sw_raw[b];
      bus.mem_addr  = addrs[$urandom_range(0, 3)];
      bus.mem_wren  = ($urandom_range(0, 15) == 0);
      bus.mem_wdata = $urandom;
      if ($urandom_range(0, 3) != 0) bus.mem_wdata[31] = 1'b0;
      #1;
      n_checks++;
      if (bus.rd_hit !== (bus.mem_addr == 32'd97 || bus.mem_addr == 32'd98))
        $display("FAIL rand_hit c=%0d addr=%0d got=%b", c, bus.mem_addr, bus.rd_hit);
      else n_pass++;
      n_checks++;
      if (bus.rd_data !== exp_read(bus.mem_addr))
        $display("FAIL rand_data c=%0d addr=%0d got=%h want=%h", c, bus.mem_addr, bus.rd_data, exp_read(bus.mem_addr));
      else n_pass++;
    end
    @(negedge clock);
    bus.mem_wren = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    btn_raw = '0; sw_raw = '0;
    bus.mem_addr = 32'd0; bus.mem_wren = 1'b0; bus.mem_wdata = 32'd0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_w1c();
    test_saturation();
    test_multi();
    test_switches();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
